// File: rtl/dcls_fault_manager.sv
// Fault manager behind the DCLS lockstep comparator.
// It blanks, filters for persistence and latches diagnostics for raw mismatches.
module dcls_fault_manager #(
   parameter int NUM_SIGNALS    = 8,
   parameter int PERSIST_CYCLES = 2,
   parameter int BLANK_CYCLES   = 4,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmp_error,
   input  logic [NUM_SIGNALS-1:0] cmp_vector,
   input  logic                   err_clear,
   input  logic                   err_inject,
   output logic                   fault_alarm,
   output logic                   fault_irq,
   output logic [1:0]             fault_state,
   output logic [NUM_SIGNALS-1:0] fault_sticky,
   output logic [(NUM_SIGNALS > 1 ? $clog2(NUM_SIGNALS) : 1)-1:0] first_fault_idx,
   output logic [CNT_WIDTH-1:0]   mismatch_count
);

   localparam int IW = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1;
   localparam int BW = $clog2(BLANK_CYCLES + 1);
   localparam int PW = $clog2(PERSIST_CYCLES + 1);
   localparam logic [BW-1:0]        BLANK_LAST  = BW'(BLANK_CYCLES - 1);
   localparam logic [PW-1:0]        PERSIST_TGT = PW'(PERSIST_CYCLES);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      S_BLANK   = 2'b00,
      S_MONITOR = 2'b01,
      S_PENDING = 2'b10,
      S_FAULT   = 2'b11
   } state_t;

   state_t                 state, state_nxt;
   logic [BW-1:0]          blank_cnt, blank_cnt_nxt;
   logic [PW-1:0]          persist_cnt, persist_cnt_nxt;
   logic                   eff_err;
   logic [NUM_SIGNALS-1:0] eff_vec;
   logic [IW-1:0]          low_idx;
   logic                   fault_entry;

   always_comb begin
      eff_err    = cmp_error | err_inject;
      eff_vec    = cmp_vector;
      eff_vec[0] = cmp_vector[0] | err_inject;
   end

   // Lowest set bit wins: scan downwards so the last hit is the smallest index.
   always_comb begin
      low_idx = '0;
      for (int i = NUM_SIGNALS - 1; i >= 0; i--) begin
         if (eff_vec[i]) low_idx = IW'(i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_BLANK;
         blank_cnt   <= '0;
         persist_cnt <= '0;
      end else begin
         state       <= state_nxt;
         blank_cnt   <= blank_cnt_nxt;
         persist_cnt <= persist_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      blank_cnt_nxt   = blank_cnt;
      persist_cnt_nxt = persist_cnt;
      if (err_clear) begin
         state_nxt       = S_BLANK;
         blank_cnt_nxt   = '0;
         persist_cnt_nxt = '0;
      end else begin
         unique case (state)
            S_BLANK: begin
               if (blank_cnt == BLANK_LAST) begin
                  state_nxt     = S_MONITOR;
                  blank_cnt_nxt = '0;
               end else begin
                  blank_cnt_nxt = blank_cnt + 1'b1;
               end
            end
            S_MONITOR: begin
               if (eff_err) begin
                  persist_cnt_nxt = PW'(1);
                  state_nxt       = (PERSIST_CYCLES == 1) ? S_FAULT : S_PENDING;
               end
            end
            S_PENDING: begin
               if (eff_err) begin
                  persist_cnt_nxt = persist_cnt + 1'b1;
                  if (persist_cnt_nxt == PERSIST_TGT) state_nxt = S_FAULT;
               end else begin
                  persist_cnt_nxt = '0;
                  state_nxt       = S_MONITOR;
               end
            end
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_BLANK;
         endcase
      end
   end

   assign fault_entry = (state_nxt == S_FAULT) && (state != S_FAULT);

   // Diagnostics; the lifetime counter survives err_clear and only rst zeroes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault_irq       <= 1'b0;
         fault_sticky    <= '0;
         first_fault_idx <= '0;
         mismatch_count  <= '0;
      end else begin
         fault_irq <= fault_entry;
         if (err_clear) begin
            fault_sticky    <= '0;
            first_fault_idx <= '0;
         end else begin
            if (state != S_BLANK) fault_sticky <= fault_sticky | eff_vec;
            if (fault_entry)      first_fault_idx <= low_idx;
         end
         if ((state != S_BLANK) && eff_err && (mismatch_count != CNT_MAX))
            mismatch_count <= mismatch_count + 1'b1;
      end
   end

   assign fault_alarm = (state == S_FAULT);
   assign fault_state = state;

endmodule

// File: tb/tb_dcls_fault_manager.sv
// Directed bench for dcls_fault_manager; a second narrow-counter instance covers saturation.
module tb_dcls_fault_manager;

   logic       clk;
   logic       rst;
   logic       cmp_error;
   logic [7:0] cmp_vector;
   logic       err_clear;
   logic       err_inject;
   logic       fault_alarm;
   logic       fault_irq;
   logic [1:0] fault_state;
   logic [7:0] fault_sticky;
   logic [2:0] first_fault_idx;
   logic [15:0] mismatch_count;

   logic       s_error;
   logic [7:0] s_vector;
   logic       s_alarm;
   logic       s_irq;
   logic [1:0] s_state;
   logic [7:0] s_sticky;
   logic [2:0] s_idx;
   logic [3:0] s_count;

   int tests_run = 0;
   int tests_failed = 0;

   dcls_fault_manager #(
      .NUM_SIGNALS(8), .PERSIST_CYCLES(2), .BLANK_CYCLES(4), .CNT_WIDTH(16)
   ) dut (
      .clk(clk), .rst(rst), .cmp_error(cmp_error), .cmp_vector(cmp_vector),
      .err_clear(err_clear), .err_inject(err_inject), .fault_alarm(fault_alarm),
      .fault_irq(fault_irq), .fault_state(fault_state), .fault_sticky(fault_sticky),
      .first_fault_idx(first_fault_idx), .mismatch_count(mismatch_count)
   );

   dcls_fault_manager #(
      .NUM_SIGNALS(8), .PERSIST_CYCLES(30), .BLANK_CYCLES(4), .CNT_WIDTH(4)
   ) dut_sat (
      .clk(clk), .rst(rst), .cmp_error(s_error), .cmp_vector(s_vector),
      .err_clear(1'b0), .err_inject(1'b0), .fault_alarm(s_alarm),
      .fault_irq(s_irq), .fault_state(s_state), .fault_sticky(s_sticky),
      .first_fault_idx(s_idx), .mismatch_count(s_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic [1:0] st, input logic alarm,
                           input logic irq, input logic [7:0] sticky,
                           input logic [2:0] idx, input logic [15:0] cnt);
      checkOutput({tag, ".state"},  32'(fault_state),     32'(st));
      checkOutput({tag, ".alarm"},  32'(fault_alarm),     32'(alarm));
      checkOutput({tag, ".irq"},    32'(fault_irq),       32'(irq));
      checkOutput({tag, ".sticky"}, 32'(fault_sticky),    32'(sticky));
      checkOutput({tag, ".idx"},    32'(first_fault_idx), 32'(idx));
      checkOutput({tag, ".count"},  32'(mismatch_count),  32'(cnt));
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic applyStimulus(input logic err, input logic [7:0] vec,
                                input logic clr, input logic inj);
      cmp_error  = err;
      cmp_vector = vec;
      err_clear  = clr;
      err_inject = inj;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      cmp_error = 1'b0; cmp_vector = 8'h00; err_clear = 1'b0; err_inject = 1'b0;
      s_error = 1'b0; s_vector = 8'h00;
      #12;
      checkAll("reset", 2'b00, 0, 0, 8'h00, 3'd0, 16'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Blanking: mismatches during the first four edges are ignored
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
         checkOutput($sformatf("blank%0d.state", i), 32'(fault_state), (i < 4) ? 32'd0 : 32'd1);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkAll("blank_done", 2'b01, 0, 0, 8'h00, 3'd0, 16'd0);

      // Transient single-cycle mismatch
      applyStimulus(1'b1, 8'h04, 1'b0, 1'b0);
      checkAll("trans_pend", 2'b10, 0, 0, 8'h04, 3'd0, 16'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkAll("trans_back", 2'b01, 0, 0, 8'h04, 3'd0, 16'd1);

      // Persistent two-cycle mismatch confirms a fault
      applyStimulus(1'b1, 8'h30, 1'b0, 1'b0);
      checkAll("pers_pend", 2'b10, 0, 0, 8'h34, 3'd0, 16'd2);
      applyStimulus(1'b1, 8'h30, 1'b0, 1'b0);
      checkAll("pers_fault", 2'b11, 1, 1, 8'h34, 3'd4, 16'd3);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkAll("pers_hold", 2'b11, 1, 0, 8'h34, 3'd4, 16'd3);

      // Clear while the mismatch is still present
      applyStimulus(1'b1, 8'h30, 1'b1, 1'b0);
      checkAll("clr", 2'b00, 0, 0, 8'h00, 3'd0, 16'd4);
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1'b1, 8'h30, 1'b0, 1'b0);
         checkAll($sformatf("clr_blank%0d", i), 2'b00, 0, 0, 8'h00, 3'd0, 16'd4);
      end
      applyStimulus(1'b1, 8'h30, 1'b0, 1'b0);
      checkAll("clr_mon", 2'b01, 0, 0, 8'h00, 3'd0, 16'd4);
      applyStimulus(1'b1, 8'h30, 1'b0, 1'b0);
      checkAll("clr_pend", 2'b10, 0, 0, 8'h30, 3'd0, 16'd5);
      applyStimulus(1'b1, 8'h30, 1'b0, 1'b0);
      checkAll("refault", 2'b11, 1, 1, 8'h30, 3'd4, 16'd6);
      applyStimulus(1'b1, 8'h30, 1'b0, 1'b0);
      checkAll("refault_hold", 2'b11, 1, 0, 8'h30, 3'd4, 16'd7);

      // Injection path, then asynchronous reset in FAULT
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkAll("clr2", 2'b00, 0, 0, 8'h00, 3'd0, 16'd7);
      for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkAll("clr2_mon", 2'b01, 0, 0, 8'h00, 3'd0, 16'd7);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkAll("inj_pend", 2'b10, 0, 0, 8'h01, 3'd0, 16'd8);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkAll("inj_fault", 2'b11, 1, 1, 8'h01, 3'd0, 16'd9);
      err_inject = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkAll("async_rst", 2'b00, 0, 0, 8'h00, 3'd0, 16'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Saturation on the 4-bit counter instance: 4 blank edges, then 20 mismatches
      s_error = 1'b1;
      s_vector = 8'h80;
      for (int i = 1; i <= 24; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
         if (i == 18) checkOutput("sat_14", 32'(s_count), 32'd14);
         if (i == 19) checkOutput("sat_15", 32'(s_count), 32'd15);
      end
      checkOutput("sat_hold", 32'(s_count), 32'd15);
      checkOutput("sat_state", 32'(s_state), 32'd2);
      checkOutput("sat_alarm", 32'(s_alarm), 32'd0);
      checkOutput("idle_count", 32'(mismatch_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
